// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding, widths and period helper for the traffic scheduler
package traffic_pkg;

  localparam int PERIOD_W = 24;
  localparam int LEVEL_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LVLUP = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Wide intermediate so (level-1)*dec never wraps before the clamp decision.
  function automatic logic [PERIOD_W-1:0] level_period(
    input logic [LEVEL_W-1:0]  level,
    input logic [PERIOD_W-1:0] base,
    input logic [PERIOD_W-1:0] dec_step,
    input logic [PERIOD_W-1:0] min_p
  );
    logic [30:0] dec;
    logic [30:0] diff;
    dec  = (31'(level) - 31'd1) * 31'(dec_step);
    diff = 31'(base) - dec;
    if ((31'(base) > dec) && (diff >= 31'(min_p)))
      return diff[PERIOD_W-1:0];
    return min_p;
  endfunction

endpackage

// File: rtl/traffic_sched_if.sv
// rtl/traffic_sched_if.sv - game control inputs and level/step outputs of the traffic scheduler
interface traffic_sched_if
  import traffic_pkg::*;
  #(parameter int NUM_LANES = 4) ();

  logic                 i_start;
  logic                 i_frog_goal;
  logic                 i_frog_hit;
  logic [LEVEL_W-1:0]   o_level;
  logic [NUM_LANES-1:0] o_lane_step;
  logic [1:0]           o_state;
  logic                 o_running;
  logic                 o_level_up;

  modport master (
    output i_start, i_frog_goal, i_frog_hit,
    input  o_level, o_lane_step, o_state, o_running, o_level_up
  );

  modport slave (
    input  i_start, i_frog_goal, i_frog_hit,
    output o_level, o_lane_step, o_state, o_running, o_level_up
  );

endinterface

// File: rtl/traffic_sched_tick_timer.sv
// rtl/traffic_sched_tick_timer.sv - base tick counter; >= compare lets a shrunk period fire at once
module tick_timer
  import traffic_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;

  assign tick = enable && (count >= (period - 24'd1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n)
      count <= '0;
    else if (!enable || tick)
      count <= '0;
    else
      count <= count + 24'd1;
  end

endmodule

// File: rtl/traffic_sched.sv
// rtl/traffic_sched.sv - level/game-state scheduler issuing per-lane step strobes to the car movers
module traffic_sched
  import traffic_pkg::*;
#(
  parameter int                  NUM_LANES   = 4,
  parameter logic [PERIOD_W-1:0] BASE_PERIOD = 24'd1000000,
  parameter logic [PERIOD_W-1:0] PERIOD_DEC  = 24'd50000,
  parameter logic [PERIOD_W-1:0] MIN_PERIOD  = 24'd200000,
  parameter logic [LEVEL_W-1:0]  MAX_LEVEL   = 7'd16,
  parameter logic [3:0]          PAUSE_TICKS = 4'd8
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  traffic_sched_if.slave bus
);

  state_t               state;
  logic [LEVEL_W-1:0]   level;
  logic [NUM_LANES-1:0] lane_step;
  logic                 level_up;
  logic                 running;
  logic [3:0]           pause_cnt;
  logic [2:0]           lane_cnt [NUM_LANES];
  logic [PERIOD_W-1:0]  period;
  logic                 tick;

  assign period = level_period(level, BASE_PERIOD, PERIOD_DEC, MIN_PERIOD);

  tick_timer u_tick_timer (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .enable  ((state == ST_RUN) || (state == ST_LVLUP)),
    .period  (period),
    .tick    (tick)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state     <= ST_IDLE;
      level     <= 7'd1;
      lane_step <= '0;
      level_up  <= 1'b0;
      running   <= 1'b0;
      pause_cnt <= '0;
      for (int k = 0; k < NUM_LANES; k++) lane_cnt[k] <= '0;
    end else begin
      lane_step <= '0;
      level_up  <= 1'b0;
      case (state)
        ST_IDLE: begin
          for (int k = 0; k < NUM_LANES; k++) lane_cnt[k] <= '0;
          pause_cnt <= '0;
          if (bus.i_start) begin
            state   <= ST_RUN;
            level   <= 7'd1;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          // A tick coinciding with goal/hit is dropped so no strobe leaks out of RUN.
          if (bus.i_frog_hit) begin
            state   <= ST_OVER;
            running <= 1'b0;
          end else if (bus.i_frog_goal) begin
            level     <= (level >= MAX_LEVEL) ? MAX_LEVEL : level + 7'd1;
            level_up  <= 1'b1;
            pause_cnt <= '0;
            for (int k = 0; k < NUM_LANES; k++) lane_cnt[k] <= '0;
            state     <= ST_LVLUP;
            running   <= 1'b0;
          end else if (tick) begin
            for (int k = 0; k < NUM_LANES; k++) begin
              if (lane_cnt[k] == 3'(k)) begin
                lane_step[k] <= 1'b1;
                lane_cnt[k]  <= '0;
              end else begin
                lane_cnt[k]  <= lane_cnt[k] + 3'd1;
              end
            end
          end
        end
        ST_LVLUP: begin
          if (tick) begin
            pause_cnt <= pause_cnt + 4'd1;
            if (pause_cnt == PAUSE_TICKS - 4'd1) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          for (int k = 0; k < NUM_LANES; k++) lane_cnt[k] <= '0;
          pause_cnt <= '0;
          if (bus.i_start) begin
            state   <= ST_RUN;
            level   <= 7'd1;
            running <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_level     = level;
  assign bus.o_lane_step = lane_step;
  assign bus.o_state     = state;
  assign bus.o_running   = running;
  assign bus.o_level_up  = level_up;

endmodule

// File: tb/tb_traffic_sched.sv
// tb/tb_traffic_sched.sv - directed plus random stimulus against a tick-counting reference model
module tb_traffic_sched;
  import traffic_pkg::*;

  localparam int NL    = 4;
  localparam int BASE  = 10;
  localparam int DEC   = 2;
  localparam int MINP  = 5;
  localparam int MAXL  = 4;
  localparam int PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_sched_if #(.NUM_LANES(NL)) bus ();

  traffic_sched #(
    .NUM_LANES   (NL),
    .BASE_PERIOD (24'(BASE)),
    .PERIOD_DEC  (24'(DEC)),
    .MIN_PERIOD  (24'(MINP)),
    .MAX_LEVEL   (7'(MAXL)),
    .PAUSE_TICKS (4'(PAUSE))
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: game state 0..3, level, base count, ticks since RUN entry, pause ticks.
  int m_state = 0, m_level = 1, m_cnt = 0, m_ticks = 0, m_pause = 0;
  int m_step = 0, m_lvlup = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int period_of(input int lvl);
    int d;
    d = (lvl - 1) * DEC;
    if (BASE > d && BASE - d >= MINP) return BASE - d;
    return MINP;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit g, input bit h);
    int  per;
    bit  tick;
    rst_n           = r;
    bus.i_start     = s;
    bus.i_frog_goal = g;
    bus.i_frog_hit  = h;
    per    = period_of(m_level);
    tick   = (m_state == 1 || m_state == 2) && (m_cnt >= per - 1);
    m_step = 0;
    m_lvlup = 0;
    if (!r) begin
      m_state = 0; m_level = 1; m_cnt = 0; m_ticks = 0; m_pause = 0;
    end else begin
      m_cnt = (m_state == 1 || m_state == 2) ? (tick ? 0 : m_cnt + 1) : 0;
      case (m_state)
        0, 3: if (s) begin m_state = 1; m_level = 1; m_ticks = 0; end
        1: begin
          if (h) m_state = 3;
          else if (g) begin
            m_level = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
            m_lvlup = 1; m_ticks = 0; m_pause = 0; m_state = 2;
          end else if (tick) begin
            m_ticks++;
            for (int k = 0; k < NL; k++)
              if (m_ticks % (k + 1) == 0) m_step |= (1 << k);
          end
        end
        default: if (tick) begin
          m_pause++;
          if (m_pause == PAUSE) begin m_state = 1; m_ticks = 0; end
        end
      endcase
    end
    @(posedge clk);
    #1;
    check("state",   32'(bus.o_state),     32'(m_state));
    check("level",   32'(bus.o_level),     32'(m_level));
    check("step",    32'(bus.o_lane_step), 32'(m_step));
    check("running", 32'(bus.o_running),   32'(m_state == 1));
    check("lvlup",   32'(bus.o_level_up),  32'(m_lvlup));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 60 && m_state != 1; i++) cyc(1, 0, 0, 0);
    check("reach_run", 32'(bus.o_state), 32'd1);
  endtask

  initial begin
    bus.i_start = 0; bus.i_frog_goal = 0; bus.i_frog_hit = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("rst_level", 32'(bus.o_level), 32'd1);
    check("rst_state", 32'(bus.o_state), 32'd0);

    cyc(1, 1, 0, 0);
    idle(9);
    check("pre_first_step", 32'(bus.o_lane_step), 32'd0);
    idle(1);
    check("first_step", 32'(bus.o_lane_step), 32'b0001);
    idle(50);

    cyc(1, 0, 1, 0);
    check("goal_level", 32'(bus.o_level), 32'd2);
    check("goal_pulse", 32'(bus.o_level_up), 32'd1);
    wait_run();
    idle(20);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 0);
      wait_run();
      idle(12);
    end
    check("sat_level", 32'(bus.o_level), 32'd4);

    cyc(1, 0, 0, 1);
    cyc(1, 1, 0, 0);
    idle(5);
    cyc(1, 0, 1, 0);
    wait_run();
    idle(7);
    cyc(1, 0, 1, 1);
    check("hit_wins", 32'(bus.o_state), 32'd3);
    check("over_level", 32'(bus.o_level), 32'd2);
    idle(15);
    cyc(1, 1, 0, 0);
    check("restart_level", 32'(bus.o_level), 32'd1);

    idle(8);
    cyc(1, 0, 1, 0);
    wait_run();
    cyc(1, 0, 1, 0);
    idle(2);
    cyc(0, 1, 0, 0);
    check("rst_lvlup_state", 32'(bus.o_state), 32'd0);
    check("rst_lvlup_level", 32'(bus.o_level), 32'd1);

    for (int i = 0; i < 6000; i++)
      cyc($urandom_range(0, 399) != 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 199) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
